// File: rtl/div_unit_pkg.sv
// Shared definitions for the multi-cycle MIPS DIV/DIVU divider.
package div_unit_pkg;

  localparam int unsigned DIV_WIDTH = 32;
  localparam int unsigned DIV_CNT_W = 6;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    DIV  = 2'b01,
    DONE = 2'b10
  } state_t;

  // Counter value seen on the edge that performs the final restoring step.
  function automatic int unsigned last_iter(input int unsigned width);
    return width - 1;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration on the {rem,quo} shift pair.
module div_step
  import div_unit_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // One extra bit keeps the compare exact for unsigned divisors above 2^(WIDTH-1).
  always_comb begin
    shifted  = {rem, quo[WIDTH-1]};
    diff     = shifted - {1'b0, divisor};
    rem_next = shifted[WIDTH-1:0];
    quo_next = {quo[WIDTH-2:0], 1'b0};
    if (shifted >= {1'b0, divisor}) begin
      rem_next    = diff[WIDTH-1:0];
      quo_next[0] = 1'b1;
    end
  end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle signed/unsigned divider: quotient to lo, remainder to hi, with EX stall handshake.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH,
  parameter int unsigned CNT_W = DIV_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             annul,
  output logic             stall,
  output logic             busy,
  output logic             ready,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(last_iter(WIDTH));

  state_t           state;
  state_t           state_next;
  logic             accept;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvsr;
  logic             neg_quo;
  logic             neg_rem;
  logic [WIDTH-1:0] rem_step;
  logic [WIDTH-1:0] quo_step;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic [WIDTH-1:0] fix_hi;
  logic [WIDTH-1:0] fix_lo;
  logic [WIDTH-1:0] hold_hi;
  logic [WIDTH-1:0] hold_lo;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem),
    .quo      (quo),
    .divisor  (dvsr),
    .rem_next (rem_step),
    .quo_next (quo_step)
  );

  // Two's-complement magnitudes; the most negative value maps to its unsigned magnitude.
  assign abs_a  = (signed_div && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
  assign abs_b  = (signed_div && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;
  assign fix_lo = neg_quo ? (~quo + WIDTH'(1)) : quo;
  assign fix_hi = neg_rem ? (~rem + WIDTH'(1)) : rem;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    stall      = 1'b0;
    busy       = 1'b0;
    ready      = 1'b0;
    case (state)
      IDLE: begin
        if (start && !annul) begin
          accept     = 1'b1;
          stall      = 1'b1;
          state_next = DIV;
        end
      end
      DIV: begin
        stall = 1'b1;
        busy  = 1'b1;
        if (annul) begin
          state_next = IDLE;
        end else if (cnt == LAST_CNT) begin
          state_next = DONE;
        end
      end
      DONE: begin
        busy       = 1'b1;
        ready      = !annul;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Result is visible during the ready cycle and committed to the hold registers on its edge.
  assign hi = ready ? fix_hi : hold_hi;
  assign lo = ready ? fix_lo : hold_lo;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      rem     <= '0;
      quo     <= '0;
      dvsr    <= '0;
      neg_quo <= 1'b0;
      neg_rem <= 1'b0;
      hold_hi <= '0;
      hold_lo <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            cnt     <= '0;
            rem     <= '0;
            quo     <= abs_a;
            dvsr    <= abs_b;
            neg_quo <= signed_div & (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_rem <= signed_div & a[WIDTH-1];
          end
        end
        DIV: begin
          rem <= rem_step;
          quo <= quo_step;
          cnt <= cnt + CNT_W'(1);
        end
        DONE: begin
          if (!annul) begin
            hold_hi <= fix_hi;
            hold_lo <= fix_lo;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Directed and randomized checks of div_unit against an arithmetic reference model.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        signed_div;
  logic [31:0] a;
  logic [31:0] b;
  logic        annul;
  logic        stall;
  logic        busy;
  logic        ready;
  logic [31:0] hi;
  logic [31:0] lo;

  int tests = 0;
  int fails = 0;
  logic [31:0] prev_lo = '0;
  logic [31:0] prev_hi = '0;

  div_unit dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .signed_div (signed_div),
    .a          (a),
    .b          (b),
    .annul      (annul),
    .stall      (stall),
    .busy       (busy),
    .ready      (ready),
    .hi         (hi),
    .lo         (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // MIPS semantics: truncating division, remainder takes the dividend sign; /0 yields all-ones magnitude.
  function automatic void ref_div(input logic sd, input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] q, output logic [31:0] r);
    longint sx;
    longint sy;
    if (y == 32'd0) begin
      r = x;
      q = (sd && x[31]) ? 32'h0000_0001 : 32'hFFFF_FFFF;
    end else if (sd) begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      q  = 32'(sx / sy);
      r  = 32'(sx % sy);
    end else begin
      q = x / y;
      r = x % y;
    end
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Launch one op from IDLE and check stall window, latency, result and hold behaviour.
  task automatic run_op(input logic sd, input logic [31:0] x, input logic [31:0] y, input string tag);
    logic [31:0] eq;
    logic [31:0] er;
    int          lat;
    logic        stall_ok;
    ref_div(sd, x, y, eq, er);
    signed_div = sd;
    a          = x;
    b          = y;
    start      = 1'b1;
    #1;
    check({tag, "_stall_req"}, 32'(stall), 32'd1);
    step();
    start    = 1'b0;
    lat      = 1;
    stall_ok = 1'b1;
    while (!ready && lat < 100) begin
      if (!stall) stall_ok = 1'b0;
      step();
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'd33);
    check({tag, "_stall_div"}, 32'(stall_ok), 32'd1);
    check({tag, "_stall_done"}, 32'(stall), 32'd0);
    check({tag, "_lo"}, lo, eq);
    check({tag, "_hi"}, hi, er);
    step();
    check({tag, "_ready_pulse"}, 32'(ready), 32'd0);
    check({tag, "_lo_hold"}, lo, eq);
    check({tag, "_hi_hold"}, hi, er);
    prev_lo = eq;
    prev_hi = er;
  endtask

  initial begin
    logic        saw;
    int          lat;
    logic        sd;
    logic [31:0] x;
    logic [31:0] y;

    rst = 1'b1; start = 1'b0; signed_div = 1'b0; a = '0; b = '0; annul = 1'b0;
    #12;
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    rst = 1'b0;
    step();

    run_op(1'b0, 32'd100, 32'd7, "divu_100_7");
    check("divu_100_7_lo_const", lo, 32'd14);
    check("divu_100_7_hi_const", hi, 32'd2);
    run_op(1'b1, 32'hFFFF_FFF9, 32'd2, "div_m7_2");
    check("div_m7_2_lo_const", lo, 32'hFFFF_FFFD);
    check("div_m7_2_hi_const", hi, 32'hFFFF_FFFF);
    run_op(1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, "div_m7_m2");
    check("div_m7_m2_lo_const", lo, 32'd3);
    check("div_m7_m2_hi_const", hi, 32'hFFFF_FFFF);
    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, "div_min_m1");
    check("div_min_m1_lo_const", lo, 32'h8000_0000);
    check("div_min_m1_hi_const", hi, 32'd0);
    run_op(1'b0, 32'd5, 32'd0, "divu_5_0");
    check("divu_5_0_lo_const", lo, 32'hFFFF_FFFF);
    check("divu_5_0_hi_const", hi, 32'd5);
    run_op(1'b1, 32'hFFFF_FFF6, 32'd0, "div_m10_0");

    // Annul during DIV cycle 10.
    signed_div = 1'b0; a = 32'd50; b = 32'd3; start = 1'b1;
    step();
    start = 1'b0;
    repeat (9) step();
    annul = 1'b1;
    #1;
    check("annul_div_stall_hold", 32'(stall), 32'd1);
    step();
    annul = 1'b0;
    #1;
    check("annul_div_stall_drop", 32'(stall), 32'd0);
    check("annul_div_busy", 32'(busy), 32'd0);
    saw = 1'b0;
    repeat (40) begin
      if (ready) saw = 1'b1;
      step();
    end
    check("annul_div_no_ready", 32'(saw), 32'd0);
    check("annul_div_lo_keep", lo, prev_lo);
    check("annul_div_hi_keep", hi, prev_hi);
    run_op(1'b0, 32'd60, 32'd4, "divu_60_4");
    check("divu_60_4_lo_const", lo, 32'd15);

    // Annul and start together in IDLE: nothing begins.
    start = 1'b1; annul = 1'b1; a = 32'd9; b = 32'd2;
    #1;
    check("annul_start_stall", 32'(stall), 32'd0);
    step();
    start = 1'b0; annul = 1'b0;
    #1;
    check("annul_start_busy", 32'(busy), 32'd0);

    // Annul in DONE suppresses ready and the result commit.
    signed_div = 1'b0; a = 32'd1000; b = 32'd9; start = 1'b1;
    step();
    start = 1'b0;
    repeat (32) step();
    check("annul_done_busy", 32'(busy), 32'd1);
    check("annul_done_stall", 32'(stall), 32'd0);
    annul = 1'b1;
    #1;
    check("annul_done_ready", 32'(ready), 32'd0);
    check("annul_done_lo_keep", lo, prev_lo);
    step();
    annul = 1'b0;
    #1;
    check("annul_done_idle", 32'(busy), 32'd0);
    check("annul_done_hi_keep", hi, prev_hi);
    check("annul_done_lo_after", lo, prev_lo);

    // Start held high with operands changing while busy.
    signed_div = 1'b0; a = 32'd100; b = 32'd7; start = 1'b1;
    step();
    lat = 1;
    while (!ready && lat < 100) begin
      a = $urandom;
      b = $urandom;
      step();
      lat++;
    end
    check("held_latency", 32'(lat), 32'd33);
    check("held_lo", lo, 32'd14);
    check("held_hi", hi, 32'd2);
    a = 32'd81; b = 32'd9;
    step();
    check("held_single_ready", 32'(ready), 32'd0);
    check("held_restart_stall", 32'(stall), 32'd1);
    check("held_restart_idle", 32'(busy), 32'd0);
    step();
    start = 1'b0;
    lat = 1;
    while (!ready && lat < 100) begin
      step();
      lat++;
    end
    check("held_second_latency", 32'(lat), 32'd33);
    check("held_second_lo", lo, 32'd9);
    check("held_second_hi", hi, 32'd0);
    step();

    // Randomized operands.
    for (int i = 0; i < 16; i++) begin
      sd = 1'($urandom_range(0, 1));
      x  = $urandom;
      case ($urandom_range(0, 3))
        0:       y = 32'($urandom_range(0, 15));
        1:       y = 32'hFFFF_FFFF - 32'($urandom_range(0, 15));
        default: y = $urandom;
      endcase
      run_op(sd, x, y, $sformatf("rand%0d", i));
    end

    // Asynchronous reset mid-DIV.
    run_op(1'b0, 32'd77, 32'd5, "pre_rst");
    signed_div = 1'b0; a = 32'd500; b = 32'd7; start = 1'b1;
    step();
    start = 1'b0;
    repeat (5) step();
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_stall", 32'(stall), 32'd0);
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_ready", 32'(ready), 32'd0);
    check("async_rst_hi", hi, 32'd0);
    check("async_rst_lo", lo, 32'd0);
    #3;
    rst = 1'b0;
    step();
    run_op(1'b0, 32'd9, 32'd3, "divu_9_3");
    check("divu_9_3_lo_const", lo, 32'd3);
    check("divu_9_3_hi_const", hi, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
